// File: rtl/ibr128_regfile.sv
// ibr128_regfile: register-mapped front end for the IBR128 block cipher core.
// Holds KEY/DIN/CTRL/STATUS/DOUT, runs the start/done handshake with the core
// and returns read data with a fixed one-cycle latency.
// Optional feature: define IBR128_REGFILE_IRQ_EN to add the irq output and
// CTRL.IRQ_EN (bit2); without it CTRL bit2 reads 0 and ignores writes.

module ibr128_regfile #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         ibr_clk,
  input  logic         ibr_reset_n,
  input  logic         ibr_cs,
  input  logic         ibr_write,
  input  logic         ibr_read,
  input  logic [4:0]   ibr_addr,
  input  logic [31:0]  ibr_writedata,
  output logic [31:0]  ibr_readdata,
  output logic         core_start,
  output logic         core_mode,
  output logic [127:0] core_key,
  output logic [127:0] core_din,
`ifdef IBR128_REGFILE_IRQ_EN
  output logic         irq,
`endif
  input  logic [127:0] core_dout,
  input  logic         core_done
);

  // Counter width follows from TIMEOUT_CYCLES.
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [4:0] ADDR_CTRL   = 5'h08;
  localparam logic [4:0] ADDR_STATUS = 5'h09;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    CAPTURE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;

  logic [31:0] key_q  [4];
  logic [31:0] key_d  [4];
  logic [31:0] din_q  [4];
  logic [31:0] din_d  [4];
  logic [31:0] dout_q [4];
  logic [31:0] dout_d [4];

  logic        mode_q, mode_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        to_q, to_d;
  logic [31:0] rdata_q, rdata_d;

`ifdef IBR128_REGFILE_IRQ_EN
  logic        irq_en_q, irq_en_d;
  logic        irq_q;
`endif

  logic        busy;
  logic        wr_en, rd_en;
  logic        wr_key, wr_din, wr_ctrl, wr_status;
  logic        start_req;
  logic        capture;
  logic        expire;
  logic        bus_err;
  logic [2:0]  w1c;
  logic [31:0] ctrl_rd;
  logic [31:0] status_rd;
  logic [31:0] rd_mux;

  assign busy      = (state_q != IDLE);
  assign wr_en     = ibr_cs & ibr_write;
  assign rd_en     = ibr_cs & ibr_read;
  assign wr_key    = wr_en && (ibr_addr[4:2] == 3'b000);
  assign wr_din    = wr_en && (ibr_addr[4:2] == 3'b001);
  assign wr_ctrl   = wr_en && (ibr_addr == ADDR_CTRL);
  assign wr_status = wr_en && (ibr_addr == ADDR_STATUS);
  assign start_req = wr_ctrl && !busy && ibr_writedata[0];
  assign bus_err   = busy && (wr_key || wr_din || wr_ctrl);
  assign w1c       = wr_status ? ibr_writedata[3:1] : '0;

  assign core_key     = {key_q[3], key_q[2], key_q[1], key_q[0]};
  assign core_din     = {din_q[3], din_q[2], din_q[1], din_q[0]};
  assign core_mode    = mode_q;
  assign core_start   = start_q;
  assign ibr_readdata = rdata_q;

`ifdef IBR128_REGFILE_IRQ_EN
  assign irq     = irq_q;
  assign ctrl_rd = {29'b0, irq_en_q, mode_q, 1'b0};
`else
  assign ctrl_rd = {30'b0, mode_q, 1'b0};
`endif
  assign status_rd = {28'b0, to_q, err_q, done_q, busy};

  // Read mux over pre-write register values; unmapped addresses read zero.
  always_comb begin
    rd_mux = '0;
    unique case (ibr_addr)
      5'h00, 5'h01, 5'h02, 5'h03: rd_mux = key_q[ibr_addr[1:0]];
      5'h04, 5'h05, 5'h06, 5'h07: rd_mux = din_q[ibr_addr[1:0]];
      ADDR_CTRL:                  rd_mux = ctrl_rd;
      ADDR_STATUS:                rd_mux = status_rd;
      5'h0C, 5'h0D, 5'h0E, 5'h0F: rd_mux = dout_q[ibr_addr[1:0]];
      default:                    rd_mux = '0;
    endcase
  end

  // Operation sequencer: next state, start pulse, timeout counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    capture = 1'b0;
    expire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_req) state_d = LOAD;
      end
      LOAD: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // core_done is tested first so it wins over a coincident expiry.
        if (core_done) begin
          state_d = CAPTURE;
        end else if (cnt_q == CNT_LAST) begin
          expire  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register file next-state: writes locked while busy, sticky flags with set-wins W1C.
  always_comb begin
    key_d   = key_q;
    din_d   = din_q;
    dout_d  = dout_q;
    mode_d  = mode_q;
    rdata_d = rdata_q;
`ifdef IBR128_REGFILE_IRQ_EN
    irq_en_d = irq_en_q;
`endif
    if (!busy) begin
      if (wr_key) key_d[ibr_addr[1:0]] = ibr_writedata;
      if (wr_din) din_d[ibr_addr[1:0]] = ibr_writedata;
      if (wr_ctrl) begin
        mode_d = ibr_writedata[1];
`ifdef IBR128_REGFILE_IRQ_EN
        irq_en_d = ibr_writedata[2];
`endif
      end
    end
    if (capture) begin
      for (int unsigned i = 0; i < 4; i++) begin
        dout_d[i] = core_dout[32*i +: 32];
      end
    end
    done_d = (done_q & ~w1c[0]) | capture;
    err_d  = (err_q & ~w1c[1]) | bus_err | expire;
    to_d   = (to_q & ~w1c[2]) | expire;
    if (rd_en) rdata_d = rd_mux;
  end

  // Sequencer state register.
  always_ff @(posedge ibr_clk) begin
    if (!ibr_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  // Register file and read-data register.
  always_ff @(posedge ibr_clk) begin
    if (!ibr_reset_n) begin
      key_q   <= '{default: '0};
      din_q   <= '{default: '0};
      dout_q  <= '{default: '0};
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      key_q   <= key_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      err_q   <= err_d;
      to_q    <= to_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef IBR128_REGFILE_IRQ_EN
  // Registered interrupt: enable qualified by any pending DONE/ERR flag.
  always_ff @(posedge ibr_clk) begin
    if (!ibr_reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_en_q & (done_q | err_q);
    end
  end
`endif

endmodule

// File: tb/tb_ibr128_regfile.sv
// Bench for ibr128_regfile: two instances (default timeout and TIMEOUT_CYCLES=16)
// share one IBR bus; each has its own responder core. A cycle-level model derived
// from the register map and operation timeline is compared every cycle, and
// literal "pins" check selected values against hand-computed constants.

module tb_ibr128_regfile;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;

  logic [1:0][31:0]  rdata_o;
  logic [1:0]        start_o;
  logic [1:0]        mode_o;
  logic [1:0][127:0] key_o;
  logic [1:0][127:0] din_o;
  logic [1:0][127:0] cdout;
  logic [1:0]        done_i;
  logic [1:0]        pulse = '0;
  logic [1:0]        inject = '0;
`ifdef IBR128_REGFILE_IRQ_EN
  logic [1:0]        irq_o;
`endif

  int lat [2] = '{20, 0};
  int ccnt [2] = '{0, 0};

  int n_chk = 0;
  int n_pass = 0;

  logic        pin_en = 1'b0;
  int          pin_sel = 0;
  int          pin_dut = 0;
  logic [31:0] pin_exp = '0;
  string       pin_name = "";

  assign done_i = pulse | inject;

  initial forever #5 clk = ~clk;

  ibr128_regfile #(.TIMEOUT_CYCLES(1024)) u_dut (
    .ibr_clk(clk), .ibr_reset_n(rst_n), .ibr_cs(cs), .ibr_write(wr), .ibr_read(rd),
    .ibr_addr(addr), .ibr_writedata(wdata), .ibr_readdata(rdata_o[0]),
    .core_start(start_o[0]), .core_mode(mode_o[0]), .core_key(key_o[0]), .core_din(din_o[0]),
`ifdef IBR128_REGFILE_IRQ_EN
    .irq(irq_o[0]),
`endif
    .core_dout(cdout[0]), .core_done(done_i[0])
  );

  ibr128_regfile #(.TIMEOUT_CYCLES(16)) u_dut16 (
    .ibr_clk(clk), .ibr_reset_n(rst_n), .ibr_cs(cs), .ibr_write(wr), .ibr_read(rd),
    .ibr_addr(addr), .ibr_writedata(wdata), .ibr_readdata(rdata_o[1]),
    .core_start(start_o[1]), .core_mode(mode_o[1]), .core_key(key_o[1]), .core_din(din_o[1]),
`ifdef IBR128_REGFILE_IRQ_EN
    .irq(irq_o[1]),
`endif
    .core_dout(cdout[1]), .core_done(done_i[1])
  );

  // Responder cores: done pulse sampled 'lat' edges after the start pulse is sampled.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pulse[k] = 1'b0;
      if (ccnt[k] > 0) begin
        ccnt[k] = ccnt[k] - 1;
        if (ccnt[k] == 0) pulse[k] = 1'b1;
      end
      if (start_o[k] && lat[k] != 0) ccnt[k] = lat[k];
    end
  end

  // ---------------- behavioural model ----------------
  logic [31:0] m_key  [2][4];
  logic [31:0] m_din  [2][4];
  logic [31:0] m_dout [2][4];
  logic [31:0] m_rd [2];
  logic m_mode [2], m_done [2], m_err [2], m_to [2], m_active [2], m_cap [2];
  int   m_ts [2];
  int   cyc = 0;
`ifdef IBR128_REGFILE_IRQ_EN
  logic m_ien [2], m_irq [2];
`endif

  function automatic int timeout_of(input int k);
    return (k == 0) ? 1024 : 16;
  endfunction

  function automatic logic [31:0] rmap(input int k, input logic [4:0] a, input logic b);
    logic [31:0] v;
    v = '0;
    if (a < 5'd4) v = m_key[k][a[1:0]];
    else if (a < 5'd8) v = m_din[k][a[1:0]];
    else if (a == 5'd8) begin
      v[1] = m_mode[k];
`ifdef IBR128_REGFILE_IRQ_EN
      v[2] = m_ien[k];
`endif
    end
    else if (a == 5'd9) v = {28'b0, m_to[k], m_err[k], m_done[k], b};
    else if (a >= 5'd12 && a <= 5'd15) v = m_dout[k][a[1:0]];
    return v;
  endfunction

  // Model: an operation is a timeline from its START edge ts; age = edges since ts.
  always @(posedge clk) begin
    logic b, newop, sd, se, st;
    logic [2:0] clr;
    int age;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) begin
          m_key[k][i] = '0; m_din[k][i] = '0; m_dout[k][i] = '0;
        end
        m_mode[k] = 0; m_done[k] = 0; m_err[k] = 0; m_to[k] = 0;
        m_rd[k] = '0; m_active[k] = 0; m_cap[k] = 0;
`ifdef IBR128_REGFILE_IRQ_EN
        m_ien[k] = 0; m_irq[k] = 0;
`endif
      end else begin
        b = m_active[k]; newop = 0; sd = 0; se = 0; st = 0; clr = '0;
`ifdef IBR128_REGFILE_IRQ_EN
        m_irq[k] = m_ien[k] & (m_done[k] | m_err[k]);
`endif
        if (cs && rd) m_rd[k] = rmap(k, addr, b);
        if (cs && wr) begin
          if (addr <= 5'd8) begin
            if (b) se = 1;
            else if (addr < 5'd4) m_key[k][addr[1:0]] = wdata;
            else if (addr < 5'd8) m_din[k][addr[1:0]] = wdata;
            else begin
              m_mode[k] = wdata[1];
`ifdef IBR128_REGFILE_IRQ_EN
              m_ien[k] = wdata[2];
`endif
              newop = wdata[0];
            end
          end else if (addr == 5'd9) clr = wdata[3:1];
        end
        if (b) begin
          age = cyc - m_ts[k];
          if (m_cap[k]) begin
            for (int i = 0; i < 4; i++) m_dout[k][i] = cdout[k][32*i +: 32];
            sd = 1; m_active[k] = 0; m_cap[k] = 0;
          end else if (age >= 2 && done_i[k]) begin
            m_cap[k] = 1;
          end else if (age == timeout_of(k) + 1) begin
            se = 1; st = 1; m_active[k] = 0;
          end
        end
        if (newop) begin
          m_active[k] = 1; m_ts[k] = cyc;
        end
        m_done[k] = (m_done[k] & ~clr[0]) | sd;
        m_err[k]  = (m_err[k] & ~clr[1]) | se;
        m_to[k]   = (m_to[k] & ~clr[2]) | st;
      end
    end
  end

  // ---------------- comparison ----------------
  task automatic chk(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h want %0h", name, k, act, exp);
  endtask

  // Compare DUT outputs with the model (and any posted literal pin) each cycle.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("readdata", k, 128'(rdata_o[k]), 128'(m_rd[k]));
      chk("core_start", k, 128'(start_o[k]), 128'(m_active[k] && (cyc - m_ts[k] == 1)));
      chk("core_mode", k, 128'(mode_o[k]), 128'(m_mode[k]));
      chk("core_key", k, key_o[k], {m_key[k][3], m_key[k][2], m_key[k][1], m_key[k][0]});
      chk("core_din", k, din_o[k], {m_din[k][3], m_din[k][2], m_din[k][1], m_din[k][0]});
`ifdef IBR128_REGFILE_IRQ_EN
      chk("irq", k, 128'(irq_o[k]), 128'(m_irq[k]));
`endif
    end
    if (pin_en) begin
      case (pin_sel)
        0: chk(pin_name, pin_dut, 128'(rdata_o[pin_dut]), 128'(pin_exp));
        1: chk(pin_name, pin_dut, 128'(key_o[pin_dut][31:0]), 128'(pin_exp));
`ifdef IBR128_REGFILE_IRQ_EN
        default: chk(pin_name, pin_dut, 128'(irq_o[pin_dut]), 128'(pin_exp));
`else
        default: ;
`endif
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus(input logic c, input logic w, input logic r, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = c; wr = w; rd = r; addr = a; wdata = d; pin_en = 0; inject = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) bus(0, 0, 0, 5'd0, 32'd0);
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    bus(1, 1, 0, a, d);
  endtask

  task automatic set_pin(input int sel, input int dut, input logic [31:0] exp, input string name);
    pin_en = 1; pin_sel = sel; pin_dut = dut; pin_exp = exp; pin_name = name;
  endtask

  task automatic read_pin(input logic [4:0] a, input int dut, input logic [31:0] exp, input string name);
    bus(1, 0, 1, a, 32'd0);
    set_pin(0, dut, exp, name);
  endtask

  initial begin
    cdout[0] = {4{32'hA5A5A5A5}};
    cdout[1] = {4{32'h5A5A5A5A}};
    idle(3);
    rst_n = 1;

    // Reset values across the whole map.
    for (int a = 0; a < 32; a++) read_pin(5'(a), 0, 32'h0, "rd_reset");

    // Normal operation; dut16's core never answers, so it times out.
    for (int i = 0; i < 4; i++) write(5'(i), 32'h03020100 + 32'(i) * 32'h04040404);
    for (int i = 0; i < 4; i++) write(5'(4 + i), 32'hD0D00000 + 32'(i));
    write(5'h08, 32'h1);
    idle(1); set_pin(1, 0, 32'h03020100, "key0_out");
    read_pin(5'h09, 0, 32'h1, "status_busy");
    idle(25);
    read_pin(5'h09, 0, 32'h2, "status_done");
    for (int i = 0; i < 4; i++) read_pin(5'(12 + i), 0, 32'hA5A5A5A5, "dout");
    read_pin(5'h09, 1, 32'hC, "status_timeout");
    read_pin(5'h0C, 1, 32'h0, "dout_timeout");
    idle(1); inject[1] = 1'b1;
    idle(2);
    read_pin(5'h0C, 1, 32'h0, "dout_late_done");
    write(5'h09, 32'hE);
    read_pin(5'h09, 0, 32'h0, "status_clr0");
    read_pin(5'h09, 1, 32'h0, "status_clr1");

    // Writes while busy are dropped and flag ERR.
    cdout[0] = {4{32'h3C3C3C3C}};
    write(5'h08, 32'h1);
    write(5'h00, 32'hFFFFFFFF);
    write(5'h08, 32'h1);
    idle(1); set_pin(1, 0, 32'h03020100, "key0_locked");
    read_pin(5'h09, 0, 32'h5, "status_err");
    write(5'h09, 32'h4);
    read_pin(5'h09, 0, 32'h1, "status_err_clr");
    read_pin(5'h0C, 0, 32'hA5A5A5A5, "dout_busy_old");
    idle(25);
    read_pin(5'h0C, 0, 32'h3C3C3C3C, "dout_new");
    read_pin(5'h09, 0, 32'h2, "status_done2");
    write(5'h09, 32'hE);

    // Same-cycle read+write returns pre-write value; MODE and CTRL bit2 readback.
    bus(1, 1, 1, 5'h01, 32'h12345678);
    set_pin(0, 0, 32'h07060504, "rw_prewrite");
    read_pin(5'h01, 0, 32'h12345678, "rw_postwrite");
    write(5'h08, 32'h2);
    read_pin(5'h08, 0, 32'h2, "ctrl_mode");
    write(5'h08, 32'h4);
`ifdef IBR128_REGFILE_IRQ_EN
    read_pin(5'h08, 0, 32'h4, "ctrl_irqen");
`else
    read_pin(5'h08, 0, 32'h0, "ctrl_bit2");
`endif
    write(5'h08, 32'h0);

    // Reset mid-RUN abandons the operation; a fresh START completes.
    write(5'h08, 32'h1);
    idle(5);
    rst_n = 0;
    idle(1);
    rst_n = 1;
    set_pin(1, 0, 32'h0, "key0_after_rst");
    read_pin(5'h09, 0, 32'h0, "status_after_rst");
    idle(25);
    write(5'h08, 32'h1);
    idle(26);
    read_pin(5'h09, 0, 32'h2, "status_rerun");

`ifdef IBR128_REGFILE_IRQ_EN
    write(5'h09, 32'hE);
    write(5'h08, 32'h5);
    idle(22);
    idle(1); set_pin(2, 0, 32'h0, "irq_pre");
    idle(1); set_pin(2, 0, 32'h1, "irq_set");
    write(5'h09, 32'h2);
    set_pin(2, 0, 32'h1, "irq_hold");
    idle(1); set_pin(2, 0, 32'h0, "irq_clr");
`endif

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
